// File: rtl/bram_port_arbiter_if.sv
// Client/RAM-facing signal bundle of bram_port_arbiter.
// The slave modport is the arbiter's view; master is the client/RAM side.
interface bram_port_arbiter_if #(
    parameter int unsigned NREQ   = 2,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 18
);
    localparam int unsigned ID_W = $clog2(NREQ);

    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_we;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_wdata;
    logic [NREQ-1:0]        req_ready;
    logic                   rsp_valid;
    logic [ID_W-1:0]        rsp_id;
    logic [DATA_W-1:0]      rsp_data;
    logic                   ram_ena;
    logic                   ram_wea;
    logic [ADDR_W-1:0]      ram_addra;
    logic [DATA_W-1:0]      ram_dina;
    logic                   ram_regcea;
    logic                   ram_rsta;
    logic [DATA_W-1:0]      ram_douta;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, ram_douta,
        output req_ready, rsp_valid, rsp_id, rsp_data,
        output ram_ena, ram_wea, ram_addra, ram_dina, ram_regcea, ram_rsta
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, ram_douta,
        input  req_ready, rsp_valid, rsp_id, rsp_data,
        input  ram_ena, ram_wea, ram_addra, ram_dina, ram_regcea, ram_rsta
    );
endinterface

// File: rtl/bram_rsp_pipe.sv
// Tracks in-flight reads as {valid, id} through a RD_LATENCY-deep shift register,
// aligned with the RAM read data.
module bram_rsp_pipe #(
    parameter int unsigned RD_LATENCY = 2,
    parameter int unsigned ID_W       = 1
) (
    input  logic            clka,
    input  logic            rsta_n,
    input  logic            in_valid,
    input  logic [ID_W-1:0] in_id,
    output logic            out_valid,
    output logic [ID_W-1:0] out_id
);
    logic [RD_LATENCY-1:0]           vld_q;
    logic [RD_LATENCY-1:0][ID_W-1:0] id_q;

    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            vld_q <= '0;
            id_q  <= '0;
        end else begin
            vld_q[0] <= in_valid;
            id_q[0]  <= in_id;
            for (int i = 1; i < int'(RD_LATENCY); i++) begin
                vld_q[i] <= vld_q[i-1];
                id_q[i]  <= id_q[i-1];
            end
        end
    end

    assign out_valid = vld_q[RD_LATENCY-1];
    assign out_id    = id_q[RD_LATENCY-1];
endmodule

// File: rtl/xilinx_single_port_ram_read_first.sv
// Single-port read-first block RAM; HIGH_PERFORMANCE adds an output register (latency 2).
module xilinx_single_port_ram_read_first #(
    parameter int unsigned RAM_WIDTH       = 18,
    parameter int unsigned RAM_DEPTH       = 1024,
    parameter string       RAM_PERFORMANCE = "HIGH_PERFORMANCE"
) (
    input  logic [$clog2(RAM_DEPTH)-1:0] addra,
    input  logic [RAM_WIDTH-1:0]         dina,
    input  logic                         clka,
    input  logic                         wea,
    input  logic                         ena,
    input  logic                         rsta,
    input  logic                         regcea,
    output logic [RAM_WIDTH-1:0]         douta
);
    logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];
    logic [RAM_WIDTH-1:0] ram_data;

    always_ff @(posedge clka) begin
        if (ena) begin
            if (wea) mem[addra] <= dina;
            ram_data <= mem[addra];
        end
    end

    generate
        if (RAM_PERFORMANCE == "LOW_LATENCY") begin : g_no_reg
            assign douta = ram_data;
        end else begin : g_out_reg
            logic [RAM_WIDTH-1:0] douta_reg;
            always_ff @(posedge clka) begin
                if (rsta)        douta_reg <= '0;
                else if (regcea) douta_reg <= ram_data;
            end
            assign douta = douta_reg;
        end
    endgenerate
endmodule

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter with bounded burst hold sharing one single-port read-first BRAM
// between NREQ requesters; read data returns tagged with the issuing requester id.
module bram_port_arbiter #(
    parameter int unsigned NREQ       = 2,
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned DATA_W     = 18,
    parameter int unsigned RD_LATENCY = 2,
    parameter int unsigned MAX_BURST  = 4
) (
    input logic               clka,
    input logic               rsta_n,
    bram_port_arbiter_if.slave bus
);
    localparam int unsigned ID_W  = $clog2(NREQ);
    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    // Returns {found, index} of the first valid requester at or above ptr, wrapping.
    function automatic logic [ID_W:0] find_winner(input logic [NREQ-1:0] valid,
                                                  input logic [ID_W-1:0] ptr);
        logic [ID_W:0]   res;
        logic [ID_W-1:0] sel;
        res = '0;
        for (int k = int'(NREQ) - 1; k >= 0; k--) begin
            sel = ID_W'((int'(ptr) + k) % int'(NREQ));
            if (valid[sel]) res = {1'b1, sel};
        end
        return res;
    endfunction

    logic [ID_W-1:0]  winner;
    logic             found;
    logic [NREQ-1:0]  ready;
    logic             accept;
    logic             win_we;
    logic [ID_W-1:0]  ptr_q, ptr_d, last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_nxt;

    assign {found, winner} = find_winner(bus.req_valid, ptr_q);

    // Grant is masked during reset so nothing is accepted while the state is held cleared.
    always_comb begin
        ready = '0;
        if (found && rsta_n) ready[winner] = 1'b1;
    end

    assign bus.req_ready  = ready;
    assign accept         = |(bus.req_valid & ready);
    assign win_we         = bus.req_we[winner];
    assign bus.ram_ena    = accept;
    assign bus.ram_wea    = accept & win_we;
    assign bus.ram_addra  = bus.req_addr[winner*ADDR_W +: ADDR_W];
    assign bus.ram_dina   = bus.req_wdata[winner*DATA_W +: DATA_W];
    assign bus.ram_regcea = 1'b1;
    assign bus.ram_rsta   = 1'b0;
    assign bus.rsp_data   = bus.ram_douta;

    always_comb begin
        ptr_d   = ptr_q;
        cnt_d   = '0;
        last_d  = last_q;
        cnt_nxt = CNT_W'(1);
        if (accept) begin
            last_d = winner;
            if (cnt_q != '0 && winner == last_q) cnt_nxt = cnt_q + 1'b1;
            if (cnt_nxt >= CNT_W'(MAX_BURST)) begin
                ptr_d = (int'(winner) == int'(NREQ) - 1) ? '0 : winner + 1'b1;
                cnt_d = '0;
            end else begin
                ptr_d = winner;
                cnt_d = cnt_nxt;
            end
        end
    end

    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            ptr_q  <= '0;
            cnt_q  <= '0;
            last_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            cnt_q  <= cnt_d;
            last_q <= last_d;
        end
    end

    bram_rsp_pipe #(
        .RD_LATENCY(RD_LATENCY),
        .ID_W      (ID_W)
    ) u_rsp_pipe (
        .clka     (clka),
        .rsta_n   (rsta_n),
        .in_valid (accept & ~win_we),
        .in_id    (winner),
        .out_valid(bus.rsp_valid),
        .out_id   (bus.rsp_id)
    );
endmodule
